axi_burst_master: RTL and testbench

- AXI4 full-protocol initiator that issues one burst at a time (read or write) on behalf of a local command port.
- Write data is taken from a local ready/valid stream; read data is delivered to a local ready/valid stream.
- Completion status is reported per command.
- Used as the bus-side driver for the team's AXI slave memories in block-level and subsystem benches and in DMA-style datapaths.

---
 rtl/axi_burst_master.sv | 198 +++++++++++++++++++
 tb/tb_axi_burst_master.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_master.sv
// AXI4 burst initiator: one read or write burst per local command, with
// pass-through local data streams and a per-command completion report.
module axi_burst_master #(
    parameter int C_M_AXI_ID_WIDTH   = 2,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 6
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESETN,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [C_M_AXI_ID_WIDTH-1:0]       cmd_id,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [7:0]                        cmd_len,
    input  logic [2:0]                        cmd_size,
    input  logic [1:0]                        cmd_burst,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     wr_data,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   wr_strb,
    input  logic                              wr_valid,
    output logic                              wr_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rd_data,
    output logic                              rd_last,
    output logic                              rd_valid,
    input  logic                              rd_ready,
    output logic                              done_valid,
    output logic [1:0]                        done_resp,
    output logic                              done_err,
    output logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [7:0]                        M_AXI_AWLEN,
    output logic [2:0]                        M_AXI_AWSIZE,
    output logic [1:0]                        M_AXI_AWBURST,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WLAST,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_BID,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [7:0]                        M_AXI_ARLEN,
    output logic [2:0]                        M_AXI_ARSIZE,
    output logic [1:0]                        M_AXI_ARBURST,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_RID,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RLAST,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    typedef enum logic [2:0] {IDLE, WADDR, WDATA, WRESP, RADDR, RDATA, DONE} state_t;

    state_t                          r_state;
    logic [C_M_AXI_ID_WIDTH-1:0]     r_id;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   r_addr;
    logic [7:0]                      r_len;
    logic [2:0]                      r_size;
    logic [1:0]                      r_burst;
    logic [8:0]                      r_cnt;
    logic                            r_awvalid;
    logic                            r_arvalid;
    logic                            r_bready;
    logic                            r_cmd_ready;
    logic                            r_done_valid;
    logic [1:0]                      r_done_resp;
    logic                            r_done_err;

    logic w_wdata_st;
    logic w_rdata_st;
    logic w_w_hs;
    logic w_r_hs;
    logic w_last;

    assign w_wdata_st = (r_state == WDATA);
    assign w_rdata_st = (r_state == RDATA);
    assign w_w_hs     = w_wdata_st && wr_valid && M_AXI_WREADY;
    assign w_r_hs     = w_rdata_st && M_AXI_RVALID && rd_ready;
    // 9-bit counter compare so a 256-beat burst never aliases to beat 0
    assign w_last     = (r_cnt == {1'b0, r_len});

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_state      <= IDLE;
            r_id         <= '0;
            r_addr       <= '0;
            r_len        <= '0;
            r_size       <= '0;
            r_burst      <= '0;
            r_cnt        <= '0;
            r_awvalid    <= 1'b0;
            r_arvalid    <= 1'b0;
            r_bready     <= 1'b0;
            r_cmd_ready  <= 1'b1;
            r_done_valid <= 1'b0;
            r_done_resp  <= '0;
            r_done_err   <= 1'b0;
        end else begin
            r_done_valid <= 1'b0;
            case (r_state)
                IDLE: if (cmd_valid) begin
                    r_id        <= cmd_id;
                    r_addr      <= cmd_addr;
                    r_len       <= cmd_len;
                    r_size      <= cmd_size;
                    r_burst     <= cmd_burst;
                    r_cnt       <= '0;
                    r_done_err  <= 1'b0;
                    r_done_resp <= '0;
                    r_cmd_ready <= 1'b0;
                    if (cmd_write) begin
                        r_awvalid <= 1'b1;
                        r_state   <= WADDR;
                    end else begin
                        r_arvalid <= 1'b1;
                        r_state   <= RADDR;
                    end
                end
                WADDR: if (M_AXI_AWREADY) begin
                    r_awvalid <= 1'b0;
                    r_state   <= WDATA;
                end
                WDATA: if (w_w_hs) begin
                    r_cnt <= r_cnt + 9'd1;
                    if (w_last) begin
                        r_bready <= 1'b1;
                        r_state  <= WRESP;
                    end
                end
                WRESP: if (M_AXI_BVALID) begin
                    r_bready     <= 1'b0;
                    r_done_resp  <= M_AXI_BRESP;
                    r_done_err   <= r_done_err | (M_AXI_BID != r_id);
                    r_done_valid <= 1'b1;
                    r_state      <= DONE;
                end
                RADDR: if (M_AXI_ARREADY) begin
                    r_arvalid <= 1'b0;
                    r_state   <= RDATA;
                end
                RDATA: if (w_r_hs) begin
                    r_cnt       <= r_cnt + 9'd1;
                    r_done_resp <= (M_AXI_RRESP > r_done_resp) ? M_AXI_RRESP : r_done_resp;
                    r_done_err  <= r_done_err | (M_AXI_RID != r_id) | (M_AXI_RLAST != w_last);
                    // a missing RLAST must not hang the engine
                    if (M_AXI_RLAST || w_last) begin
                        r_done_valid <= 1'b1;
                        r_state      <= DONE;
                    end
                end
                DONE: begin
                    r_cmd_ready <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign done_valid    = r_done_valid;
    assign done_resp     = r_done_resp;
    assign done_err      = r_done_err;

    assign M_AXI_AWID    = r_id;
    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_AWLEN   = r_len;
    assign M_AXI_AWSIZE  = r_size;
    assign M_AXI_AWBURST = r_burst;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_ARID    = r_id;
    assign M_AXI_ARADDR  = r_addr;
    assign M_AXI_ARLEN   = r_len;
    assign M_AXI_ARSIZE  = r_size;
    assign M_AXI_ARBURST = r_burst;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_BREADY  = r_bready;

    assign M_AXI_WDATA   = wr_data;
    assign M_AXI_WSTRB   = wr_strb;
    assign M_AXI_WVALID  = w_wdata_st & wr_valid;
    assign M_AXI_WLAST   = w_wdata_st & w_last;
    assign wr_ready      = w_wdata_st & M_AXI_WREADY;

    assign M_AXI_RREADY  = w_rdata_st & rd_ready;
    assign rd_valid      = w_rdata_st & M_AXI_RVALID;
    assign rd_data       = M_AXI_RDATA;
    assign rd_last       = w_rdata_st & M_AXI_RLAST;

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master: AXI slave model plus scoreboards for
// W beats, local read beats and completion reports.
module tb_axi_burst_master;
    localparam int IW = 2;
    localparam int DW = 32;
    localparam int AW = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [IW-1:0] cmd_id = '0;
    logic [AW-1:0] cmd_addr = '0;
    logic [7:0]    cmd_len = '0;
    logic [2:0]    cmd_size = '0;
    logic [1:0]    cmd_burst = '0;
    logic [DW-1:0] wr_data = '0;
    logic [3:0]    wr_strb = '0;
    logic          wr_valid = 1'b0, rd_ready = 1'b0;
    logic          cmd_ready, wr_ready, rd_last, rd_valid, done_valid, done_err;
    logic [DW-1:0] rd_data;
    logic [1:0]    done_resp;

    logic [IW-1:0] awid, arid;
    logic [AW-1:0] awaddr, araddr;
    logic [7:0]    awlen, arlen;
    logic [2:0]    awsize, arsize;
    logic [1:0]    awburst, arburst;
    logic          awvalid, arvalid, wlast, wvalid, bready, rready;
    logic [DW-1:0] wdata;
    logic [3:0]    wstrb;

    logic          s_awready = 1'b0, s_wready = 1'b0, s_bvalid = 1'b0, s_arready = 1'b0;
    logic          s_rvalid = 1'b0, s_rlast = 1'b0;
    logic [IW-1:0] s_bid = '0, s_rid = '0;
    logic [1:0]    s_bresp = '0, s_rresp = '0;
    logic [DW-1:0] s_rdata = '0;

    axi_burst_master #(.C_M_AXI_ID_WIDTH(IW), .C_M_AXI_DATA_WIDTH(DW), .C_M_AXI_ADDR_WIDTH(AW)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_id(cmd_id),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .done_valid(done_valid), .done_resp(done_resp), .done_err(done_err),
        .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
        .M_AXI_AWBURST(awburst), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(s_awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast), .M_AXI_WVALID(wvalid),
        .M_AXI_WREADY(s_wready),
        .M_AXI_BID(s_bid), .M_AXI_BRESP(s_bresp), .M_AXI_BVALID(s_bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
        .M_AXI_ARBURST(arburst), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(s_arready),
        .M_AXI_RID(s_rid), .M_AXI_RDATA(s_rdata), .M_AXI_RRESP(s_rresp), .M_AXI_RLAST(s_rlast),
        .M_AXI_RVALID(s_rvalid), .M_AXI_RREADY(rready)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // slave behaviour knobs, written only by the stimulus block
    bit            cfg_rand = 1'b0;
    logic [IW-1:0] cfg_bid = '0, cfg_rid = '0;
    logic [1:0]    cfg_bresp = '0, cfg_rresp = '0;
    logic [DW-1:0] cfg_rbase = '0;
    int            cfg_rresp_at = -1, cfg_rlast_at = 0;

    // scoreboards
    logic [35:0] exp_w[$];
    logic [32:0] exp_r[$];
    logic [2:0]  exp_done[$];

    logic [IW-1:0] rec_awid = '0, rec_arid = '0;
    logic [AW-1:0] rec_awaddr = '0, rec_araddr = '0;
    logic [7:0]    rec_awlen = '0, rec_arlen = '0;
    logic [1:0]    rec_arburst = '0;
    int            w_beats = 0, r_idx = 0, r_n = 0, done_seen = 0;
    logic          pend_b = 1'b0, aw_wait = 1'b0, prev_done = 1'b0;
    logic [21:0]   aw_prev = '0;

    function automatic logic [1:0] beat_resp(input int i);
        return (i == cfg_rresp_at) ? cfg_rresp : 2'd0;
    endfunction

    // slave model and output monitors, sampled at the active edge
    always @(posedge clk) begin
        logic [35:0] ew;
        logic [32:0] er;
        logic [2:0]  ed;
        if (!rst_n) begin
            s_awready <= 1'b0; s_wready <= 1'b0; s_bvalid <= 1'b0; s_arready <= 1'b0;
            s_rvalid <= 1'b0; s_rlast <= 1'b0; pend_b <= 1'b0; aw_wait <= 1'b0; prev_done <= 1'b0;
        end else begin
            s_awready <= cfg_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            s_wready  <= cfg_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            s_arready <= cfg_rand ? 1'($urandom_range(0, 1)) : 1'b1;

            if (aw_wait) chk("aw_stable", {awvalid, awid, awaddr, awlen, awsize, awburst}, {1'b1, aw_prev[20:0]});
            aw_wait <= awvalid && !s_awready;
            aw_prev <= {awvalid, awid, awaddr, awlen, awsize, awburst};
            if (awvalid && s_awready) begin
                rec_awid <= awid; rec_awaddr <= awaddr; rec_awlen <= awlen; w_beats <= 0;
            end

            if (wvalid && s_wready) begin
                if (exp_w.size() == 0) chk("w_extra", 1, 0);
                else begin
                    ew = exp_w.pop_front();
                    chk("wdata", {wstrb, wdata}, ew);
                end
                chk("wlast", wlast, (w_beats == int'(rec_awlen)));
                w_beats <= w_beats + 1;
                if (wlast) pend_b <= 1'b1;
            end

            if (s_bvalid && bready) s_bvalid <= 1'b0;
            else if (pend_b && !s_bvalid) begin
                s_bvalid <= 1'b1; s_bid <= cfg_bid; s_bresp <= cfg_bresp; pend_b <= 1'b0;
            end

            if (arvalid && s_arready) begin
                rec_arid <= arid; rec_araddr <= araddr; rec_arlen <= arlen; rec_arburst <= arburst;
                r_n <= int'(arlen) + 1; r_idx <= 0;
                s_rvalid <= 1'b1; s_rid <= cfg_rid; s_rdata <= cfg_rbase;
                s_rresp <= beat_resp(0); s_rlast <= (cfg_rlast_at == 0);
            end else if (s_rvalid && rready) begin
                if (r_idx == r_n - 1 || r_idx == cfg_rlast_at) s_rvalid <= 1'b0;
                else begin
                    r_idx <= r_idx + 1;
                    s_rdata <= cfg_rbase + DW'(r_idx + 1);
                    s_rresp <= beat_resp(r_idx + 1);
                    s_rlast <= (cfg_rlast_at == r_idx + 1);
                end
            end

            if (rd_valid && rd_ready) begin
                if (exp_r.size() == 0) chk("r_extra", 1, 0);
                else begin
                    er = exp_r.pop_front();
                    chk("rd_beat", {rd_last, rd_data}, er);
                end
            end

            prev_done <= done_valid;
            if (done_valid) begin
                chk("done_1cyc", prev_done, 0);
                if (exp_done.size() == 0) chk("done_extra", 1, 0);
                else begin
                    ed = exp_done.pop_front();
                    chk("done_resp_err", {done_resp, done_err}, ed);
                end
                done_seen <= done_seen + 1;
            end
        end
    end

    task automatic send_cmd(input bit wr, input int id, input int addr, input int len,
                            input int size, input int burst);
        bit hs = 1'b0;
        int cyc = 0;
        cmd_write = wr; cmd_id = IW'(id); cmd_addr = AW'(addr);
        cmd_len = 8'(len); cmd_size = 3'(size); cmd_burst = 2'(burst);
        cmd_valid = 1'b1;
        while (!hs && cyc < 50) begin
            @(negedge clk); hs = cmd_ready;
            @(posedge clk); #1; cyc++;
        end
        cmd_valid = 1'b0;
        cmd_id = '0; cmd_addr = '1; cmd_len = 8'hFF;
        if (!hs) chk("cmd_timeout", 0, 1);
    endtask

    function automatic logic [3:0] strb_of(input int i);
        return 4'hF ^ 4'(i % 3);
    endfunction

    // pushes all expected beats, then feeds the stream; stops early after stop_at beats
    task automatic stream_w(input int n, input logic [DW-1:0] base, input bit gaps, input int stop_at);
        int idx = 0;
        int cyc = 0;
        bit hs;
        for (int i = 0; i < n; i++) exp_w.push_back({strb_of(i), base + DW'(i)});
        while (idx < n && idx != stop_at && cyc < 1000) begin
            wr_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            wr_data = base + DW'(idx); wr_strb = strb_of(idx);
            @(negedge clk); hs = wr_valid && wr_ready;
            @(posedge clk); #1; cyc++;
            if (hs) idx++;
        end
        if (idx == stop_at) begin
            wr_valid = 1'b1; wr_data = base + DW'(idx); wr_strb = strb_of(idx);
        end else begin
            wr_valid = 1'b0;
            if (idx != n) chk("wstream_timeout", idx, n);
        end
    endtask

    // rdmode: 0 rd_ready low, 1 held high, 2 toggling
    task automatic wait_done(input int target, input int rdmode);
        int cyc = 0;
        while (done_seen < target && cyc < 1000) begin
            rd_ready = (rdmode == 2) ? ~rd_ready : (rdmode == 1);
            @(posedge clk); #1; cyc++;
        end
        rd_ready = 1'b0;
        if (done_seen < target) chk("done_timeout", done_seen, target);
    endtask

    initial begin
        int nd = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready, wr_ready, rd_valid}, 0);
        chk("rst_done", {done_valid, done_resp, done_err}, 0);
        chk("rst_fields", {awid, awaddr, awlen, awsize, awburst}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single-beat write
        cfg_bid = 2'd1; cfg_bresp = 2'd0;
        exp_done.push_back(3'b000); nd++;
        send_cmd(1, 1, 'h04, 0, 2, 1);
        stream_w(1, 32'hA5A5_0001, 0, -1);
        wait_done(nd, 0);
        chk("aw1_fields", {rec_awid, rec_awaddr, rec_awlen}, {2'd1, 6'h04, 8'd0});
        chk("w1_beats", w_beats, 1);

        // 16-beat INCR write, random slave readiness and stream gaps
        cfg_rand = 1'b1; cfg_bid = 2'd2;
        exp_done.push_back(3'b000); nd++;
        send_cmd(1, 2, 'h10, 15, 2, 1);
        stream_w(16, 32'hC0DE_0000, 1, -1);
        wait_done(nd, 0);
        chk("aw16_len", rec_awlen, 15);
        chk("w16_beats", w_beats, 16);
        chk("w16_drained", exp_w.size(), 0);
        cfg_rand = 1'b0;

        // 4-beat WRAP read, rd_ready toggling
        cfg_rid = 2'd2; cfg_rbase = 32'h10; cfg_rlast_at = 3; cfg_rresp_at = -1;
        for (int i = 0; i < 4; i++) exp_r.push_back({(i == 3), 32'h10 + 32'(i)});
        exp_done.push_back(3'b000); nd++;
        send_cmd(0, 2, 'h08, 3, 2, 2);
        wait_done(nd, 2);
        chk("ar_fields", {rec_arid, rec_araddr, rec_arlen, rec_arburst}, {2'd2, 6'h08, 8'd3, 2'd2});
        chk("r4_drained", exp_r.size(), 0);

        // 3-beat read with SLVERR on beat 2
        cfg_rid = 2'd0; cfg_rbase = 32'h200; cfg_rlast_at = 2; cfg_rresp_at = 1; cfg_rresp = 2'd2;
        for (int i = 0; i < 3; i++) exp_r.push_back({(i == 2), 32'h200 + 32'(i)});
        exp_done.push_back({2'd2, 1'b0}); nd++;
        send_cmd(0, 0, 'h20, 2, 2, 1);
        wait_done(nd, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("resp_held", {done_resp, done_err}, {2'd2, 1'b0});
        cfg_rresp_at = -1;

        // BID mismatch on write
        cfg_bid = 2'd3; cfg_bresp = 2'd0;
        exp_done.push_back(3'b001); nd++;
        send_cmd(1, 1, 'h00, 1, 2, 1);
        stream_w(2, 32'h0BAD_0000, 0, -1);
        wait_done(nd, 0);

        // early RLAST: len=3 but slave ends after beat 2
        cfg_rid = 2'd1; cfg_rbase = 32'h300; cfg_rlast_at = 1;
        exp_r.push_back({1'b0, 32'h300}); exp_r.push_back({1'b1, 32'h301});
        exp_done.push_back(3'b001); nd++;
        send_cmd(0, 1, 'h04, 3, 2, 1);
        wait_done(nd, 1);

        // missing RLAST: counter terminates the burst
        cfg_rbase = 32'h400; cfg_rlast_at = 99;
        exp_r.push_back({1'b0, 32'h400}); exp_r.push_back({1'b0, 32'h401});
        exp_done.push_back(3'b001); nd++;
        send_cmd(0, 1, 'h08, 1, 2, 1);
        wait_done(nd, 1);
        chk("r_drained", exp_r.size(), 0);

        // reset during beat 3 of an 8-beat write
        cfg_bid = 2'd1;
        send_cmd(1, 1, 'h0C, 7, 2, 1);
        stream_w(8, 32'h7700_0000, 0, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_valids", {awvalid, wvalid, arvalid, bready, rready, wr_ready, done_valid}, 0);
        wr_valid = 1'b0;
        repeat (3) @(posedge clk);
        exp_w.delete();
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_cmd_ready", cmd_ready, 1);
        chk("abort_no_done", done_seen, nd);

        exp_done.push_back(3'b000); nd++;
        send_cmd(1, 1, 'h18, 0, 2, 1);
        stream_w(1, 32'h1234_5678, 0, -1);
        wait_done(nd, 0);
        chk("post_rst_aw", {rec_awaddr, rec_awlen}, {6'h18, 8'd0});
        chk("post_rst_beats", w_beats, 1);
        repeat (4) @(posedge clk);
        #1;
        chk("done_count", done_seen, nd);
        chk("done_drained", exp_done.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
